ram12x73_fifo_ctrl: RTL and testbench

Synchronous FIFO controller that turns the vendor 12x73 RAM macro (`mem_16nm_ram12x73`: one write port, one read port, 2-cycle read latency) into a valid/ready FIFO for the router ingress queues. It drives the macro's write and read ports, tracks occupancy and pointers, and hides read latency with a 3-entry output skid buffer so the consumer sees a plain streaming interface at full throughput. The macro sits beside this block in the queue wrapper; BIST ports are tied off in the wrapper and are not touched here.

---
 rtl/ram12x73_pkg.sv | 16 +
 rtl/ram12x73_fifo_ctrl_if.sv | 32 +++
 rtl/ram12x73_skid.sv | 47 ++++
 rtl/ram12x73_fifo_ctrl.sv | 81 ++++++++
 tb/tb_ram12x73_fifo_ctrl.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram12x73_pkg.sv
// Shared constants and types for the 12x73 RAM-backed FIFO controller.
package ram12x73_pkg;
  localparam int DEPTH      = 12;
  localparam int WIDTH      = 73;
  localparam int ADDR_W     = 4;
  localparam int RD_LAT     = 2;
  localparam int SKID_DEPTH = RD_LAT + 1;
  localparam int SKID_CW    = $clog2(SKID_DEPTH + 1);
  localparam int CRED_W     = $clog2(RD_LAT + SKID_DEPTH + 1);

  typedef logic [WIDTH-1:0] ram_entry_t;

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
endpackage

// File: rtl/ram12x73_fifo_ctrl_if.sv
// Streaming in/out handshake plus the RAM macro port bundle.
interface ram12x73_fifo_ctrl_if;
  import ram12x73_pkg::*;

  logic              in_valid;
  logic              in_ready;
  ram_entry_t        in_data;
  logic              out_valid;
  logic              out_ready;
  ram_entry_t        out_data;
  logic [ADDR_W-1:0] count;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_wr_addr;
  ram_entry_t        ram_wr_data;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_rd_addr;
  ram_entry_t        ram_rd_data;

  // Environment side: producer, consumer and RAM macro.
  modport master (
    output in_valid, in_data, out_ready, ram_rd_data,
    input  in_ready, out_valid, out_data, count,
           ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_en, ram_rd_addr
  );

  // Controller side.
  modport slave (
    input  in_valid, in_data, out_ready, ram_rd_data,
    output in_ready, out_valid, out_data, count,
           ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_en, ram_rd_addr
  );
endinterface

// File: rtl/ram12x73_skid.sv
// In-order register FIFO that catches RAM read data; head is always entry 0.
module ram12x73_skid
  import ram12x73_pkg::*;
#(
  parameter int N = SKID_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic               pop_i,
  input  ram_entry_t         data_i,
  output ram_entry_t         head_o,
  output logic [SKID_CW-1:0] cnt_o
);
  ram_entry_t [N-1:0] ent_q, ent_d;
  logic [SKID_CW-1:0] cnt_q, cnt_d, wr_idx;

  always_comb begin
    ent_d  = ent_q;
    wr_idx = cnt_q - SKID_CW'(pop_i);
    if (pop_i) begin
      for (int i = 0; i < N - 1; i++) ent_d[i] = ent_q[i+1];
    end
    // Write lands behind the survivors, so push and pop can share a cycle.
    for (int i = 0; i < N; i++) begin
      if (push_i && wr_idx == SKID_CW'(i)) ent_d[i] = data_i;
    end
    cnt_d = cnt_q + SKID_CW'(push_i) - SKID_CW'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  assign head_o = ent_q[0];
  assign cnt_o  = cnt_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_i && !pop_i && cnt_q == SKID_CW'(N)));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop_i && cnt_q == '0));
endmodule

// File: rtl/ram12x73_fifo_ctrl.sv
// FIFO controller around a 2-cycle-latency RAM macro; read latency hidden by a skid buffer.
module ram12x73_fifo_ctrl
  import ram12x73_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  ram12x73_fifo_ctrl_if.slave   bus
);
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]  ram_occ_q, ram_occ_d;
  logic [RD_LAT-1:0]  vld_pipe_q, vld_pipe_d;
  logic [CRED_W-1:0]  infl_cnt, ahead;
  logic [SKID_CW-1:0] skid_cnt;
  logic               in_ready, out_valid;
  logic               push, pop, issue, skid_push;
  ram_entry_t         skid_head;

  // in_ready falls with rst itself so nothing is accepted in a reset cycle.
  assign in_ready  = !rst && (ram_occ_q < ADDR_W'(DEPTH));
  assign out_valid = (skid_cnt != '0);
  assign push      = bus.in_valid && in_ready;
  assign pop       = out_valid && bus.out_ready;
  assign skid_push = vld_pipe_q[RD_LAT-1];

  always_comb begin
    infl_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) infl_cnt = infl_cnt + CRED_W'(vld_pipe_q[i]);
  end

  // Credit: reads in flight plus buffered entries, net of this cycle's pop,
  // must leave room in the skid for one more returning word.
  assign ahead = infl_cnt + CRED_W'(skid_cnt) - CRED_W'(pop);
  assign issue = !rst && (ram_occ_q != '0) && (ahead < CRED_W'(SKID_DEPTH));

  always_comb begin
    wr_ptr_d   = push  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = issue ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    ram_occ_d  = ram_occ_q + ADDR_W'(push) - ADDR_W'(issue);
    vld_pipe_d = {vld_pipe_q[RD_LAT-2:0], issue};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_occ_q  <= '0;
      vld_pipe_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_occ_q  <= ram_occ_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  ram12x73_skid #(.N(SKID_DEPTH)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .push_i (skid_push),
    .pop_i  (pop),
    .data_i (bus.ram_rd_data),
    .head_o (skid_head),
    .cnt_o  (skid_cnt)
  );

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_data    = skid_head;
  assign bus.count       = ram_occ_q + ADDR_W'(infl_cnt) + ADDR_W'(skid_cnt);
  assign bus.ram_wr_en   = push;
  assign bus.ram_wr_addr = wr_ptr_q;
  assign bus.ram_wr_data = bus.in_data;
  assign bus.ram_rd_en   = issue;
  assign bus.ram_rd_addr = rd_ptr_q;

  a_occ_bound: assert property (@(posedge clk) disable iff (rst)
    ram_occ_q <= ADDR_W'(DEPTH));
  a_ptr_bound: assert property (@(posedge clk) disable iff (rst)
    (wr_ptr_q < ADDR_W'(DEPTH)) && (rd_ptr_q < ADDR_W'(DEPTH)));
endmodule

// File: tb/tb_ram12x73_fifo_ctrl.sv
// Directed + random bench for ram12x73_fifo_ctrl with a behavioral 2-cycle RAM.
module tb_ram12x73_fifo_ctrl;
  import ram12x73_pkg::*;

  logic clk, rst;
  ram12x73_fifo_ctrl_if bus();

  ram12x73_fifo_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioral macro: registered write, read data RD_LAT cycles after rd_en.
  ram_entry_t mem [DEPTH];
  ram_entry_t rd_s1;
  always @(posedge clk) begin
    if (bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
    if (bus.ram_rd_en) rd_s1 <= mem[bus.ram_rd_addr];
    bus.ram_rd_data <= rd_s1;
  end

  int errs = 0, nchk = 0;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchk++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic adv(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); endtask

  function automatic ram_entry_t mkdat(input int i);
    return {9'h1A5, 32'(i), ~32'(i)};
  endfunction

  // Scoreboard: expected data order and expected occupancy.
  ram_entry_t q[$];
  ram_entry_t last_pop, exp_d;
  int cnt_m = 0, npop = 0;
  bit sb_en = 0;
  always @(negedge clk) begin
    if (sb_en) begin
      if (rst) begin
        q.delete();
        cnt_m = 0;
      end else begin
        chk("count", bus.count, cnt_m);
        if (bus.out_valid && bus.out_ready) begin
          chk("pop_q_nonempty", q.size() > 0, 1);
          if (q.size() > 0) begin
            exp_d = q.pop_front();
            chk("pop_data", bus.out_data, exp_d);
          end
          last_pop = bus.out_data;
          npop++;
          cnt_m--;
        end
        if (bus.in_valid && bus.in_ready) begin
          q.push_back(bus.in_data);
          cnt_m++;
        end
      end
    end
  end

  int pushed, rd_pulses;
  task automatic fill(input int n, input int base);
    pushed = 0;
    rd_pulses = 0;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 200 && pushed < n; c++) begin
      bus.in_data = mkdat(base + pushed);
      smp();
      if (bus.in_ready) pushed++;
      if (bus.ram_rd_en) rd_pulses++;
      adv();
    end
    bus.in_data = mkdat(base + pushed);
    chk("fill_pushed", pushed, n);
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      smp();
      if (bus.count == '0 && !bus.out_valid) break;
      adv();
    end
    chk("drain_count", bus.count, 0);
    adv();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: run did not finish, errors=%0d", errs);
    $fatal(1);
  end

  initial begin
    ram_entry_t v1, xf, yv;
    logic [95:0] rnd;
    int npop0, first_c, last_c, wraps, addr_bad, prev_a;
    bit have_prev;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (3) adv();
    smp();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_rd_en", bus.ram_rd_en, 0);
    chk("rst_wr_en", bus.ram_wr_en, 0);
    adv();
    rst = 1'b0;
    sb_en = 1'b1;
    smp();
    chk("post_rst_in_ready", bus.in_ready, 1);
    chk("post_rst_out_valid", bus.out_valid, 0);
    chk("post_rst_count", bus.count, 0);
    chk("post_rst_wr_addr", bus.ram_wr_addr, 0);
    chk("post_rst_rd_addr", bus.ram_rd_addr, 0);
    adv();

    // Single push latency.
    v1 = 73'h1_2345_6789_ABCD_EF01;
    bus.in_valid = 1'b1;
    bus.in_data = v1;
    smp();
    chk("t1_wr_en", bus.ram_wr_en, 1);
    chk("t1_wr_addr", bus.ram_wr_addr, 0);
    chk("t1_wr_data", bus.ram_wr_data, v1);
    adv();
    bus.in_valid = 1'b0;
    smp();
    chk("t1_c1_rd_en", bus.ram_rd_en, 1);
    chk("t1_c1_rd_addr", bus.ram_rd_addr, 0);
    chk("t1_c1_count", bus.count, 1);
    adv();
    for (int c = 2; c < 4; c++) begin
      smp();
      chk("t1_early_out_valid", bus.out_valid, 0);
      chk("t1_rd_en_once", bus.ram_rd_en, 0);
      adv();
    end
    bus.out_ready = 1'b1;
    smp();
    chk("t1_c4_out_valid", bus.out_valid, 1);
    chk("t1_c4_out_data", bus.out_data, v1);
    chk("t1_c4_count", bus.count, 1);
    adv();
    bus.out_ready = 1'b0;
    smp();
    chk("t1_c5_out_valid", bus.out_valid, 0);
    chk("t1_c5_count", bus.count, 0);
    adv();

    // Fill to 15 under backpressure, then drain in order.
    fill(15, 100);
    for (int c = 0; c < 4; c++) begin
      smp();
      chk("t2_in_ready_low", bus.in_ready, 0);
      if (bus.ram_rd_en) rd_pulses++;
      adv();
    end
    smp();
    chk("t2_count_full", bus.count, 15);
    chk("t2_rd_pulses", rd_pulses, 3);
    adv();
    npop0 = npop;
    drain();
    chk("t2_pops", npop - npop0, 15);
    chk("t2_last", last_pop, mkdat(114));

    // 40-deep stream at full throughput; pointer starts at 4 here.
    npop0 = npop;
    pushed = 0;
    first_c = -1;
    last_c = -1;
    wraps = 0;
    addr_bad = 0;
    prev_a = 0;
    have_prev = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 120; c++) begin
      bus.in_valid = (pushed < 40);
      bus.in_data = mkdat(500 + pushed);
      smp();
      if (bus.ram_wr_en) begin
        if (have_prev && prev_a == 11 && bus.ram_wr_addr == 0) wraps++;
        if (bus.ram_wr_addr > 11) addr_bad++;
        prev_a = int'(bus.ram_wr_addr);
        have_prev = 1;
      end
      if (bus.in_valid && bus.in_ready) pushed++;
      if (bus.out_valid) begin
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      adv();
      if (npop - npop0 == 40) break;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("t3_pushed", pushed, 40);
    chk("t3_pops", npop - npop0, 40);
    chk("t3_first_out", first_c, 4);
    chk("t3_back_to_back", last_c - first_c, 39);
    chk("t3_wraps", wraps, 3);
    chk("t3_addr_range", addr_bad, 0);

    // Full: pop frees a RAM slot one cycle later, then the new push lands last.
    fill(15, 1000);
    smp();
    chk("t4_count15", bus.count, 15);
    chk("t4_in_ready", bus.in_ready, 0);
    adv();
    xf = mkdat(7777);
    bus.in_data = xf;
    bus.out_ready = 1'b1;
    smp();
    chk("t4_pop_cycle_in_ready", bus.in_ready, 0);
    chk("t4_pop_cycle_out_valid", bus.out_valid, 1);
    adv();
    bus.out_ready = 1'b0;
    smp();
    chk("t4_after_pop_count", bus.count, 14);
    chk("t4_after_pop_in_ready", bus.in_ready, 1);
    adv();
    bus.in_valid = 1'b0;
    smp();
    chk("t4_refull_count", bus.count, 15);
    adv();
    drain();
    chk("t4_new_exits_last", last_pop, xf);

    // Reset with reads in flight and data in the skid.
    fill(6, 2000);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    smp();
    adv();
    smp();
    adv();
    bus.out_ready = 1'b0;
    rst = 1'b1;
    smp();
    chk("t5_rst_rd_en", bus.ram_rd_en, 0);
    chk("t5_rst_in_ready", bus.in_ready, 0);
    adv();
    rst = 1'b0;
    yv = mkdat(4242);
    bus.in_valid = 1'b1;
    bus.in_data = yv;
    smp();
    chk("t5_out_valid_cleared", bus.out_valid, 0);
    chk("t5_count_cleared", bus.count, 0);
    chk("t5_wr_addr", bus.ram_wr_addr, 0);
    adv();
    bus.in_valid = 1'b0;
    for (int c = 1; c < 4; c++) begin
      smp();
      chk("t5_stale_ignored", bus.out_valid, 0);
      adv();
    end
    bus.out_ready = 1'b1;
    smp();
    chk("t5_new_out_valid", bus.out_valid, 1);
    chk("t5_new_out_data", bus.out_data, yv);
    adv();
    bus.out_ready = 1'b0;
    smp();
    chk("t5_empty", bus.count, 0);
    adv();

    // Random valid/ready traffic against the scoreboard.
    for (int c = 0; c < 2000; c++) begin
      rnd = {$urandom(), $urandom(), $urandom()};
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data = rnd[WIDTH-1:0];
      bus.out_ready = 1'($urandom_range(0, 1));
      adv();
    end
    drain();
    chk("t6_sb_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
